taillight_seq: RTL
==================

TAILLIGHT_SEQ -- requirements
Module: taillight_seq

Interface
REQ-001 SHALL have parameter LAMPS, default 3, lamps per side; legal range 2..8.
REQ-002 SHALL have parameter TICK_DIV, default 25000000, clk cycles per sequence step; legal range >=2.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port left, input, 1, left-turn request (level).
REQ-006 SHALL have port right, input, 1, right-turn request (level).
REQ-007 SHALL have port hazard, input, 1, hazard request (level).
REQ-008 SHALL have port brake, input, 1, brake request (level).
REQ-009 SHALL have port lamp_l, output, LAMPS, left lamps; bit 0 innermost.
REQ-010 SHALL have port lamp_r, output, LAMPS, right lamps; bit 0 innermost.

Function
REQ-011 SHALL register left/right/hazard/brake once on entry; all decisions use the registered copies.
REQ-012 SHALL run a free-running tick counter 0..TICK_DIV-1; tick is asserted for one cycle when the count is TICK_DIV-1, then the count wraps to 0.
REQ-013 SHALL implement an FSM with states IDLE, LEFT, RIGHT, HAZ and a step counter 0..LAMPS.
REQ-014 SHALL compute the requested mode as: HAZ if hazard, or if left and right are both high; else LEFT if left; else RIGHT if right; else IDLE.
REQ-015 SHALL change state only on tick: if the requested mode differs from the current state, enter the requested mode with step=0; otherwise advance step.
REQ-016 SHALL wrap step in LEFT/RIGHT from LAMPS to 0 (period LAMPS+1 ticks), and in HAZ from 1 to 0 (period 2 ticks); in IDLE, step is held at 0.
REQ-017 SHALL drive the turning side in LEFT/RIGHT with the lowest `step` bits lit, ascending (for example, step=2 gives 0..011); step=0 gives all off.
REQ-018 SHALL drive both sides all-on in HAZ for step=1 and all-off for step=0.
REQ-019 SHALL drive the non-turning side in LEFT/RIGHT, and both sides in IDLE, all-off unless brake applies per REQ-025.
REQ-020 SHALL register the outputs; an output reflects state/step/brake one cycle after they change.
REQ-021 SHALL ignore requests between ticks: a request pulse that is high and low entirely between two ticks has no effect.
REQ-022 SHALL handle a left->right switch at a tick as entering RIGHT at step 0, with lamp_l cleared in the same update.

Reset
REQ-023 SHALL, while reset is high at a clk edge, set state=IDLE, step=0, tick count=0, input registers=0, lamp_l=0, lamp_r=0.
REQ-024 SHALL, when reset is asserted mid-sequence, abandon the sequence immediately and restart from IDLE after reset deasserts; the first tick is then TICK_DIV cycles after release.

Configuration
REQ-025 SHALL, when macro TAILLIGHT_BRAKE_EN is defined, apply brake as follows: all non-turning-side lamps steady on in LEFT/RIGHT; both sides steady on in IDLE; ignored in HAZ. Brake takes effect every cycle and is not gated by tick.
REQ-026 SHALL, when TAILLIGHT_BRAKE_EN is undefined, keep the brake port but ignore it entirely, and synthesise no brake logic.

Structure
REQ-027 SHALL place the state encoding (IDLE=0, LEFT=1, RIGHT=2, HAZ=3) and the LAMPS range limits as constants in shared package taillight_pkg.
REQ-028 SHALL implement the tick counter as sub-module tick_gen, with parameter TICK_DIV and ports clk, reset and tick.

Verification (LAMPS=3, TICK_DIV=4)
REQ-029 SHALL verify: reset high for 2 cycles, then left=1 -> lamp_l steps 000,001,011,111,000 and repeats, one step per 4 cycles; lamp_r=000 throughout.
REQ-030 SHALL verify: hazard=1 -> both sides alternate 111/000 every 4 cycles; asserting left or brake at the same time does not change this.
REQ-031 SHALL verify: left=1 and right=1 together -> identical to hazard behaviour.
REQ-032 SHALL verify, with TAILLIGHT_BRAKE_EN defined: right=1, brake=1 -> lamp_l=111 steady while lamp_r sequences; brake released -> lamp_l=000 two cycles later.
REQ-033 SHALL verify: left active with lamp_l=011, right switched on and left off -> at the next tick lamp_l=000 and lamp_r=000, then lamp_r=001 one tick later.
REQ-034 SHALL verify: reset pulsed while lamp_l=111 -> outputs 000 on the next edge and remain 000 for 4 cycles after release even with left held high.

Source files
------------

// File: rtl/taillight_pkg.sv
// Shared constants for the tail-light sequencer: FSM state encoding and LAMPS limits.
// Also holds the request-priority rule used by the FSM.
package taillight_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_e;

    localparam int LAMPS_MIN = 2;
    localparam int LAMPS_MAX = 8;

    // Left and right together are treated the same as a hazard request.
    function automatic state_e requested_mode(input logic left_req,
                                              input logic right_req,
                                              input logic hazard_req);
        if (hazard_req || (left_req && right_req)) begin
            return HAZ;
        end else if (left_req) begin
            return LEFT;
        end else if (right_req) begin
            return RIGHT;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/taillight_seq_tick_gen.sv
// Free-running step timer: counts 0..TICK_DIV-1 and pulses tick for one cycle on the
// terminal count.
module tick_gen
    import taillight_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    if (TICK_DIV < 2) begin : g_bad_div
        $error("tick_gen: TICK_DIV must be at least 2");
    end

    always_comb begin
        tick    = (count_q == LAST);
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/taillight_seq.sv
// Sequential turn-signal / hazard tail-light controller with registered lamp outputs.
// Optional brake overlay is compiled in only when TAILLIGHT_BRAKE_EN is defined.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] lamp_l,
    output logic [LAMPS-1:0] lamp_r
);

    localparam int STEP_W = $clog2(LAMPS + 1);
    localparam logic [LAMPS-1:0] ALL_ON = '1;

    if (LAMPS < LAMPS_MIN || LAMPS > LAMPS_MAX) begin : g_bad_lamps
        $error("taillight_seq: LAMPS out of range");
    end

    logic              tick;
    logic              left_q;
    logic              right_q;
    logic              hazard_q;
    state_e            state_q;
    state_e            state_d;
    state_e            req_mode;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [LAMPS-1:0]  bar;
    logic [LAMPS-1:0]  lamp_l_q;
    logic [LAMPS-1:0]  lamp_l_d;
    logic [LAMPS-1:0]  lamp_r_q;
    logic [LAMPS-1:0]  lamp_r_d;

`ifdef TAILLIGHT_BRAKE_EN
    logic              brake_q;
`else
    logic              unused_brake;
    assign unused_brake = brake;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        req_mode = requested_mode(left_q, right_q, hazard_q);
        state_d  = state_q;
        step_d   = step_q;
        if (tick) begin
            if (req_mode != state_q) begin
                state_d = req_mode;
                step_d  = '0;
            end else begin
                case (state_q)
                    LEFT, RIGHT: step_d = (step_q == STEP_W'(LAMPS)) ? '0 : step_q + STEP_W'(1);
                    HAZ:         step_d = (step_q == '0) ? STEP_W'(1) : '0;
                    default:     step_d = '0;
                endcase
            end
        end
    end

    // Lamp image is derived from the current state; the flop below adds one cycle.
    always_comb begin
        bar = '0;
        for (int i = 0; i < LAMPS; i++) begin
            bar[i] = (STEP_W'(i) < step_q);
        end
        lamp_l_d = '0;
        lamp_r_d = '0;
        case (state_q)
            LEFT:    lamp_l_d = bar;
            RIGHT:   lamp_r_d = bar;
            HAZ: begin
                if (step_q != '0) begin
                    lamp_l_d = ALL_ON;
                    lamp_r_d = ALL_ON;
                end
            end
            default: ;
        endcase
`ifdef TAILLIGHT_BRAKE_EN
        if (brake_q) begin
            case (state_q)
                LEFT:    lamp_r_d = ALL_ON;
                RIGHT:   lamp_l_d = ALL_ON;
                IDLE: begin
                    lamp_l_d = ALL_ON;
                    lamp_r_d = ALL_ON;
                end
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            hazard_q <= 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
            brake_q  <= 1'b0;
`endif
            state_q  <= IDLE;
            step_q   <= '0;
            lamp_l_q <= '0;
            lamp_r_q <= '0;
        end else begin
            left_q   <= left;
            right_q  <= right;
            hazard_q <= hazard;
`ifdef TAILLIGHT_BRAKE_EN
            brake_q  <= brake;
`endif
            state_q  <= state_d;
            step_q   <= step_d;
            lamp_l_q <= lamp_l_d;
            lamp_r_q <= lamp_r_d;
        end
    end

    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;

endmodule
